// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package uart_loader_pkg;

    // Loader sequencing: header byte, data bytes, one-cycle write, then sticky end states
    typedef enum logic [2:0] {
        HDR,
        BYTES,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

    // Receiver framing states for one 8N1 character
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes the pin, times mid-bit samples and reports
// each character as a one-cycle rx_valid, or rx_ferr when the stop bit is low.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             half_hit;
    logic             full_hit;

    assign half_hit = (baud_cnt == HALF_M1);
    assign full_hit = (baud_cnt == FULL_M1);
    assign rx_byte  = shift;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; a high line at the half-bit point is a glitch, not a start bit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (rx_prev && !rx_sync) state_nxt = START;
            START: if (half_hit) state_nxt = rx_sync ? IDLE : DATA;
            DATA:  if (full_hit && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:  if (full_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Baud/bit counters and the one-cycle result strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                START: baud_cnt <= half_hit ? '0 : baud_cnt + CNT_W'(1);
                DATA: begin
                    if (full_hit) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (full_hit) begin
                        baud_cnt <= '0;
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: baud_cnt <= '0;
            endcase
        end
    end

    // Data bits arrive LSB first, so shift in from the top
    always_ff @(posedge clk) begin
        if (state == DATA && full_hit) shift <= {rx_sync, shift[7:1]};
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: takes a word-count header and little-endian words over UART,
// writes them to instruction memory from address 0 and releases the CPU when done.
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter  int CLKS_PER_BIT    = 87,
    parameter  int INSTR_MEM_DEPTH = 128,
    localparam int ADDR_W          = $clog2(INSTR_MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    input  logic              enable,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_enable,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error
);

    // One extra bit so a full-depth count is representable
    localparam int CNT_W = ADDR_W + 1;

    loader_state_t    state;
    loader_state_t    state_nxt;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] words_written;
    logic [1:0]       byte_cnt;
    logic [31:0]      word_reg;
    logic             hdr_bad;
    logic             last_byte;
    logic             last_word;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    assign hdr_bad    = (rx_byte == 8'd0) || (int'({24'd0, rx_byte}) > INSTR_MEM_DEPTH);
    assign last_byte  = (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign last_word  = ((words_written + CNT_W'(1)) == n_words);

    assign imem_we    = (state == WRITE);
    assign imem_wdata = word_reg;
    assign load_busy  = (state == BYTES) || (state == WRITE);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERR);
    assign cpu_enable = load_done & enable;

    // Loader state register
    always_ff @(posedge clk) begin
        if (reset) state <= HDR;
        else       state <= state_nxt;
    end

    // Loader sequencing; DONE and ERR are left only through reset
    always_comb begin
        state_nxt = state;
        case (state)
            HDR: begin
                if (rx_ferr)       state_nxt = ERR;
                else if (rx_valid) state_nxt = hdr_bad ? ERR : BYTES;
            end
            BYTES: begin
                if (rx_ferr)                    state_nxt = ERR;
                else if (rx_valid && last_byte) state_nxt = WRITE;
            end
            WRITE:   state_nxt = last_word ? DONE : BYTES;
            DONE:    state_nxt = DONE;
            ERR:     state_nxt = ERR;
            default: state_nxt = ERR;
        endcase
    end

    // Word assembly, write address and progress counters
    always_ff @(posedge clk) begin
        if (reset) begin
            n_words       <= '0;
            words_written <= '0;
            byte_cnt      <= '0;
            word_reg      <= '0;
            imem_addr     <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (rx_valid && !rx_ferr && !hdr_bad) begin
                        n_words       <= CNT_W'(rx_byte);
                        words_written <= '0;
                        byte_cnt      <= '0;
                    end
                end
                BYTES: begin
                    if (rx_valid) begin
                        word_reg <= {rx_byte, word_reg[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    imem_addr     <= imem_addr + ADDR_W'(1);
                    words_written <= words_written + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: header table, scripted corner cases and random loads
// checked against a byte-stream model of the expected memory writes.
module tb_uart_imem_loader;

    localparam int CPB    = 8;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              uart_rx;
    logic              enable;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_enable;
    logic              load_busy;
    logic              load_done;
    logic              load_error;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [7:0] hdr;
        logic       exp_err;
        logic       exp_busy;
    } hdr_vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    logic       exp_err;
    logic       exp_done;
    logic       exp_busy;
    int         n_checks = 0;
    int         n_fail   = 0;
    hdr_vec_t   vecs[6];

    uart_imem_loader #(
        .CLKS_PER_BIT   (CPB),
        .INSTR_MEM_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .enable    (enable),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_enable(cpu_enable),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    // Record every write-strobe cycle seen by memory
    always @(negedge clk) begin
        if (imem_we) got_q.push_back('{addr: imem_addr, data: imem_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        got_q.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        if (!stop_bit) begin
            uart_rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Reference: header N, then only complete 4-byte groups become words, at most N of them
    task automatic build_model();
        int hdr;
        int nw;
        exp_q.delete();
        hdr      = int'(tx_q[0]);
        exp_err  = (hdr == 0) || (hdr > DEPTH);
        exp_done = 1'b0;
        exp_busy = 1'b0;
        if (!exp_err) begin
            nw = (tx_q.size() - 1) / 4;
            if (nw > hdr) nw = hdr;
            for (int i = 0; i < nw; i++)
                exp_q.push_back('{addr: ADDR_W'(i),
                                  data: {tx_q[4*i+4], tx_q[4*i+3], tx_q[4*i+2], tx_q[4*i+1]}});
            exp_done = (nw == hdr);
            exp_busy = !exp_done;
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_wr_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_wr_addr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check({tag, "_wr_data"}, got_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic run_load(input string tag, input bit rst_first);
        if (rst_first) do_reset();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        repeat (10) @(negedge clk);
        build_model();
        compare_writes(tag);
        check({tag, "_done"}, 32'(load_done), 32'(exp_done));
        check({tag, "_error"}, 32'(load_error), 32'(exp_err));
        check({tag, "_busy"}, 32'(load_busy), 32'(exp_busy));
    endtask

    initial begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        enable  = 1'b0;

        vecs[0] = '{hdr: 8'h00, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[1] = '{hdr: 8'h81, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{hdr: 8'hFF, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{hdr: 8'h80, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[4] = '{hdr: 8'h01, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[5] = '{hdr: 8'h05, exp_err: 1'b0, exp_busy: 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_busy", 32'(load_busy), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_error", 32'(load_error), 0);
        enable = 1'b1;
        @(negedge clk);
        check("rst_cpu_en", 32'(cpu_enable), 0);

        // Header acceptance table
        foreach (vecs[v]) begin
            do_reset();
            send_byte(vecs[v].hdr, 1'b1);
            repeat (10) @(negedge clk);
            check("hdr_error", 32'(load_error), 32'(vecs[v].exp_err));
            check("hdr_busy", 32'(load_busy), 32'(vecs[v].exp_busy));
            check("hdr_no_we", got_q.size(), 0);
            check("hdr_cpu_en", 32'(cpu_enable), 0);
        end

        // Two-word example program; cpu_enable follows enable
        tx_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load("two_word", 1'b1);
        enable = 1'b0;
        @(negedge clk);
        check("cpu_en_off", 32'(cpu_enable), 0);
        enable = 1'b1;
        @(negedge clk);
        check("cpu_en_on", 32'(cpu_enable), 1);

        // Framing error on the second data byte
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        repeat (10) @(negedge clk);
        check("ferr_error", 32'(load_error), 1);
        check("ferr_busy", 32'(load_busy), 0);
        check("ferr_no_we", got_q.size(), 0);
        check("ferr_cpu_en", 32'(cpu_enable), 0);

        // One-clock glitch on the idle line, then a normal load
        do_reset();
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch_busy", 32'(load_busy), 0);
        check("glitch_error", 32'(load_error), 0);
        tx_q = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
        run_load("after_glitch", 1'b0);

        // Reset after two data bytes, then a fresh load of 0xDEADBEEF
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        check("mid_busy", 32'(load_busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        @(negedge clk);
        check("mid_rst_busy", 32'(load_busy), 0);
        tx_q = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load("mid_reset", 1'b0);

        // Random programs, some deliberately truncated mid-program
        for (int r = 0; r < 4; r++) begin
            int n;
            int nbytes;
            n = $urandom_range(1, 6);
            nbytes = (r % 2 == 1) ? 4 * n - int'($urandom_range(1, 3)) : 4 * n;
            tx_q.delete();
            tx_q.push_back(8'(n));
            for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
            run_load("random", 1'b1);
        end

        // Full-depth program, back-to-back, data = word index
        tx_q.delete();
        tx_q.push_back(8'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            tx_q.push_back(8'(i));
            tx_q.push_back(8'h00);
            tx_q.push_back(8'h00);
            tx_q.push_back(8'h00);
        end
        run_load("full", 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (10) @(negedge clk);
        check("full_extra_no_we", got_q.size(), DEPTH);
        check("full_still_done", 32'(load_done), 1);
        check("full_no_error", 32'(load_error), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
